// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan decoder.
// Holds the active-low segment patterns for the hex digits 0..F and for a blank digit.
// The hex encoder uses the same table, so both ends of the display link agree on it.
// Pattern bit order: bit0 = segment a ... bit6 = segment g. A 0 bit lights that segment.
package seg_scan_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Result of decoding one segment pattern.
    typedef struct packed {
        logic       invalid;  // pattern is not one of SEG_0..SEG_F
        logic [3:0] nibble;   // decoded value, 0 when invalid
    } hex_dec_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bus between a seven-segment display scanner and the scan decoder.
// Ports:
//   seg_n      segment lines, active-low, bit0=a ... bit6=g
//   an_n       digit enables, active-low, one-hot while a digit is lit
//   value      last complete decoded word, digit i at [4i+3:4i]
//   valid      one-cycle strobe when value/err/digit_err update
//   err        last frame had at least one undecodable digit
//   digit_err  per-digit undecodable flags of the last frame
// Handshake: valid is a plain one-cycle strobe with no ready. The display pins cannot be
// held off, so a consumer must take value/err/digit_err on the cycle valid is high, or
// read them later since they hold until the next frame completes.
interface seg_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    valid;
    logic                    err;
    logic [NUM_DIGITS-1:0]   digit_err;

    // master: drives the display pins and observes the decoded result
    modport master (
        output seg_n, an_n,
        input  value, valid, err, digit_err
    );

    // slave: the decoder
    modport slave (
        input  seg_n, an_n,
        output value, valid, err, digit_err
    );
endinterface

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Ports:
//   seg_n  in   7  active-low segment pattern, bit0=a ... bit6=g
//   dec    out  5  {invalid, nibble}; unknown patterns (blank included) give invalid=1, nibble=0
module seg7_to_hex
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg_n,
    output hex_dec_t   dec
);

    always_comb begin
        dec.invalid = 1'b0;
        dec.nibble  = 4'h0;
        case (seg_n)
            SEG_0:   dec.nibble = 4'h0;
            SEG_1:   dec.nibble = 4'h1;
            SEG_2:   dec.nibble = 4'h2;
            SEG_3:   dec.nibble = 4'h3;
            SEG_4:   dec.nibble = 4'h4;
            SEG_5:   dec.nibble = 4'h5;
            SEG_6:   dec.nibble = 4'h6;
            SEG_7:   dec.nibble = 4'h7;
            SEG_8:   dec.nibble = 4'h8;
            SEG_9:   dec.nibble = 4'h9;
            SEG_A:   dec.nibble = 4'hA;
            SEG_B:   dec.nibble = 4'hB;
            SEG_C:   dec.nibble = 4'hC;
            SEG_D:   dec.nibble = 4'hD;
            SEG_E:   dec.nibble = 4'hE;
            SEG_F:   dec.nibble = 4'hF;
            default: dec.invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a time-multiplexed seven-segment display bus.
// Samples the segment/anode pins, waits until a digit's pins have been stable for
// STABLE_CYCLES samples, decodes the digit and collects digits until every position has
// been seen once, then publishes the whole word with a one-cycle valid strobe.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high
//   bus    seg_scan_decoder_if.slave (seg_n, an_n in; value, valid, err, digit_err out)
// Parameters:
//   NUM_DIGITS     number of anode lines
//   STABLE_CYCLES  identical consecutive samples needed to accept a digit (>= 2)
//   CNT_W          stability counter width, must hold STABLE_CYCLES-1
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                clk,
    input  logic                reset,
    seg_scan_decoder_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

    // pin samples: s_* is the current registered sample, p_* the one before
    logic [6:0]              s_seg, p_seg;
    logic [NUM_DIGITS-1:0]   s_an, p_an;
    logic [CNT_W-1:0]        cnt;

    // frame assembly
    logic [4*NUM_DIGITS-1:0] slots;
    logic [NUM_DIGITS-1:0]   seen, bad;
    logic                    complete;   // high the cycle after the frame's last accept

    // output registers
    logic [4*NUM_DIGITS-1:0] value_r;
    logic                    valid_r, err_r;
    logic [NUM_DIGITS-1:0]   digit_err_r;

    logic                    match, accept;
    logic [NUM_DIGITS-1:0]   lit, cap, seen_base;
    logic                    frame_done;
    hex_dec_t                dec;

    seg7_to_hex u_dec (
        .seg_n (s_seg),
        .dec   (dec)
    );

    always_comb begin
        match     = (s_seg == p_seg) && (s_an == p_an);
        // fires only on the count step into CNT_MAX, so a held window accepts once
        accept    = match && (cnt == CNT_PRE);
        lit       = ~s_an;
        // capture mask: the lit digit on an accept, nothing if zero or several are lit
        cap       = (accept && $onehot(lit)) ? lit : '0;
        // the edge that publishes a frame also starts the next one empty
        seen_base = complete ? '0 : seen;
        frame_done = (|cap) && ((seen_base | cap) == '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_seg       <= 7'h7F;
            p_seg       <= 7'h7F;
            s_an        <= '1;
            p_an        <= '1;
            cnt         <= '0;
            slots       <= '0;
            seen        <= '0;
            bad         <= '0;
            complete    <= 1'b0;
            value_r     <= '0;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
            digit_err_r <= '0;
        end else begin
            s_seg <= bus.seg_n;
            s_an  <= bus.an_n;
            p_seg <= s_seg;
            p_an  <= s_an;

            if (match) begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end

            seen <= seen_base | cap;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap[i]) begin
                    slots[4*i +: 4] <= dec.nibble;
                    bad[i]          <= dec.invalid;
                end else if (complete) begin
                    bad[i] <= 1'b0;
                end
            end

            complete <= frame_done;
            valid_r  <= complete;
            if (complete) begin
                value_r     <= slots;
                digit_err_r <= bad;
                err_r       <= |bad;
            end
        end
    end

    assign bus.value     = value_r;
    assign bus.valid     = valid_r;
    assign bus.err       = err_r;
    assign bus.digit_err = digit_err_r;

endmodule
